hash_arbiter: RTL and testbench

Shares one SHAKE hash core between `NUM_REQ` requesters (tree PRG, commitment, MPC challenge expansion), each of which speaks the standard hash-client interface: start pulse, streamed input read, streamed output with valid/ready, and force-done/ack termination. Sits between the signing sub-blocks and the single hash instance. Latches start requests, grants the core to one requester at a time (round-robin), and routes all hash signals to and from the owner until that owner's force-done handshake completes.

---
 rtl/hash_arbiter.sv | 155 +++++++++++++++
 tb/tb_hash_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_arbiter.sv
// Shares one SHAKE core among NUM_REQ hash clients; latches starts, grants round-robin, routes to owner until force-done ack.
// Define HASH_ARB_FIXED_PRIO_EN to make the lowest pending index always win instead of round-robin.
module hash_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_REQ-1:0]      i_req_start,
   input  logic [32*NUM_REQ-1:0]   i_req_data_in,
   input  logic [32*NUM_REQ-1:0]   i_req_in_len,
   input  logic [32*NUM_REQ-1:0]   i_req_out_len,
   input  logic [NUM_REQ-1:0]      i_req_ready,
   input  logic [NUM_REQ-1:0]      i_req_force_done,
   output logic [ADDR_W-1:0]       o_req_addr,
   output logic [NUM_REQ-1:0]      o_req_rd_en,
   output logic [31:0]             o_req_data_out,
   output logic [NUM_REQ-1:0]      o_req_valid,
   output logic [NUM_REQ-1:0]      o_req_force_done_ack,
   output logic [NUM_REQ-1:0]      o_grant,
   output logic                    o_hash_start,
   output logic [31:0]             o_hash_data_in,
   output logic [31:0]             o_hash_input_length,
   output logic [31:0]             o_hash_output_length,
   output logic                    o_hash_data_out_ready,
   output logic                    o_hash_force_done,
   input  logic [ADDR_W-1:0]       i_hash_addr,
   input  logic                    i_hash_rd_en,
   input  logic [31:0]             i_hash_data_out,
   input  logic                    i_hash_data_out_valid,
   input  logic                    i_hash_force_done_ack
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, FLUSH} state_t;
   state_t state, state_nxt;

   logic [NUM_REQ-1:0] pend, grant, win_oh, win_clr;
   logic [IDX_W-1:0]   owner, rr_ptr, win;
   logic               win_vld;
   logic [31:0]        in_len, out_len, win_in_len, win_out_len, own_data;
   logic               own_ready, own_fd, force_done, busy, take, done;

`ifndef HASH_ARB_FIXED_PRIO_EN
   logic [2*NUM_REQ-1:0] pend_dbl;
   logic [IDX_W-1:0]     off;
   logic [IDX_W:0]       sum;
`endif

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
`ifdef HASH_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (pend[i]) begin
            win     = IDX_W'(i);
            win_vld = 1'b1;
         end
      end
`else
      // Rotate pending so bit 0 is rr_ptr, pick first set, then rotate the offset back.
      pend_dbl = {pend, pend} >> rr_ptr;
      off      = '0;
      for (int j = NUM_REQ-1; j >= 0; j--) begin
         if (pend_dbl[j]) begin
            off     = IDX_W'(j);
            win_vld = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (IDX_W+1)'(NUM_REQ))
         sum = sum - (IDX_W+1)'(NUM_REQ);
      win = sum[IDX_W-1:0];
`endif
   end

   always_comb begin
      win_in_len  = '0;
      win_out_len = '0;
      own_data    = '0;
      own_ready   = 1'b0;
      own_fd      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            win_in_len  = i_req_in_len[32*i +: 32];
            win_out_len = i_req_out_len[32*i +: 32];
         end
         if (owner == IDX_W'(i)) begin
            own_data  = i_req_data_in[32*i +: 32];
            own_ready = i_req_ready[i];
            own_fd    = i_req_force_done[i];
         end
      end
   end

   assign busy    = (state == BUSY);
   assign take    = (state == IDLE) && win_vld;
   assign done    = (state == FLUSH) && i_hash_force_done_ack;
   assign win_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
   assign win_clr = take ? win_oh : '0;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = GRANT;
         GRANT:   state_nxt = BUSY;
         BUSY:    if (own_fd) state_nxt = FLUSH;
         FLUSH:   if (i_hash_force_done_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         pend       <= '0;
         grant      <= '0;
         owner      <= '0;
         rr_ptr     <= '0;
         in_len     <= '0;
         out_len    <= '0;
         force_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         pend       <= (pend & ~win_clr) | i_req_start;
         force_done <= busy & own_fd;
         if (take) begin
            owner   <= win;
            grant   <= win_oh;
            in_len  <= win_in_len;
            out_len <= win_out_len;
         end
         if (done) begin
            grant   <= '0;
            in_len  <= '0;
            out_len <= '0;
            rr_ptr  <= (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
         end
      end
   end

   // Owner routing is purely combinational on the registered owner.
   assign o_grant               = grant;
   assign o_hash_start          = (state == GRANT);
   assign o_hash_force_done     = force_done;
   assign o_hash_input_length   = in_len;
   assign o_hash_output_length  = out_len;
   assign o_hash_data_in        = busy ? own_data : '0;
   assign o_hash_data_out_ready = busy & own_ready;
   assign o_req_addr            = busy ? i_hash_addr : '0;
   assign o_req_data_out        = busy ? i_hash_data_out : '0;
   assign o_req_rd_en           = {NUM_REQ{busy & i_hash_rd_en}} & grant;
   assign o_req_valid           = {NUM_REQ{busy & i_hash_data_out_valid}} & grant;
   assign o_req_force_done_ack  = {NUM_REQ{done}} & grant;
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter: one task per scenario, inline comparisons against hand-computed values.
module tb_hash_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [N-1:0]  i_req_start, i_req_ready, i_req_force_done;
   logic [32*N-1:0] i_req_data_in, i_req_in_len, i_req_out_len;
   logic [AW-1:0] o_req_addr, i_hash_addr;
   logic [N-1:0]  o_req_rd_en, o_req_valid, o_req_force_done_ack, o_grant;
   logic [31:0]   o_req_data_out, o_hash_data_in, o_hash_input_length, o_hash_output_length;
   logic          o_hash_start, o_hash_data_out_ready, o_hash_force_done;
   logic          i_hash_rd_en, i_hash_data_out_valid, i_hash_force_done_ack;
   logic [31:0]   i_hash_data_out;

   int errors = 0;
   int checks = 0;

   hash_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req_start(i_req_start), .i_req_data_in(i_req_data_in),
      .i_req_in_len(i_req_in_len), .i_req_out_len(i_req_out_len),
      .i_req_ready(i_req_ready), .i_req_force_done(i_req_force_done),
      .o_req_addr(o_req_addr), .o_req_rd_en(o_req_rd_en),
      .o_req_data_out(o_req_data_out), .o_req_valid(o_req_valid),
      .o_req_force_done_ack(o_req_force_done_ack), .o_grant(o_grant),
      .o_hash_start(o_hash_start), .o_hash_data_in(o_hash_data_in),
      .o_hash_input_length(o_hash_input_length), .o_hash_output_length(o_hash_output_length),
      .o_hash_data_out_ready(o_hash_data_out_ready), .o_hash_force_done(o_hash_force_done),
      .i_hash_addr(i_hash_addr), .i_hash_rd_en(i_hash_rd_en),
      .i_hash_data_out(i_hash_data_out), .i_hash_data_out_valid(i_hash_data_out_valid),
      .i_hash_force_done_ack(i_hash_force_done_ack)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_req_start = '0; i_req_ready = '0; i_req_force_done = '0;
      i_req_data_in = '0; i_req_in_len = '0; i_req_out_len = '0;
      i_hash_addr = '0; i_hash_rd_en = 1'b0; i_hash_data_out = '0;
      i_hash_data_out_valid = 1'b0; i_hash_force_done_ack = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [N-1:0] m);
      i_req_start = m;
      step();
      i_req_start = '0;
   endtask

   // Bounded wait for o_hash_start; returns the grant seen with it.
   task automatic wait_start(output logic [N-1:0] g, output bit ok);
      ok = 1'b0;
      g  = '0;
      for (int c = 0; c < 12; c++) begin
         if (o_hash_start === 1'b1) begin
            ok = 1'b1;
            g  = o_grant;
            break;
         end
         step();
      end
   endtask

   // Called in BUSY: owner force-done, then core acks one cycle later; ends in IDLE.
   task automatic do_flush(input logic [N-1:0] own);
      i_req_force_done = own;
      step();
      i_req_force_done = '0;
      i_hash_force_done_ack = 1'b1;
      step();
      i_hash_force_done_ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      i_hash_rd_en = 1'b1; i_hash_data_out_valid = 1'b1; i_hash_addr = 5'd9;
      i_hash_data_out = 32'hDEAD_BEEF; i_req_ready = '1;
      #1;
      checks++;
      if ({o_grant, o_hash_start, o_hash_force_done, o_hash_input_length, o_hash_output_length} !== '0) begin
         errors++; $display("FAIL reset_ctrl: got grant=%b start=%b fd=%b", o_grant, o_hash_start, o_hash_force_done);
      end
      checks++;
      if ({o_req_rd_en, o_req_valid, o_req_force_done_ack, o_hash_data_out_ready, o_req_addr, o_req_data_out} !== '0) begin
         errors++; $display("FAIL reset_route: got rd_en=%b valid=%b ready=%b addr=%0d", o_req_rd_en, o_req_valid, o_hash_data_out_ready, o_req_addr);
      end
      checks++;
      if (dut.pend !== 3'b000) begin
         errors++; $display("FAIL reset_pend: got %b want 000", dut.pend);
      end
      clear_inputs();
   endtask

   task automatic test_single();
      do_reset();
      i_req_in_len[63:32] = 32'd384; i_req_out_len[63:32] = 32'd256;
      i_req_data_in[63:32] = 32'hCAFE_0001; i_req_data_in[31:0] = 32'h1111_1111;
      pulse_start(3'b010);
      checks++;
      if (dut.pend !== 3'b010 || o_grant !== 3'b000 || o_hash_start !== 1'b0) begin
         errors++; $display("FAIL single_pend: got pend=%b grant=%b start=%b want 010/000/0", dut.pend, o_grant, o_hash_start);
      end
      step();
      checks++;
      if (o_hash_start !== 1'b1 || o_grant !== 3'b010) begin
         errors++; $display("FAIL single_grant: got start=%b grant=%b want 1/010", o_hash_start, o_grant);
      end
      checks++;
      if (o_hash_input_length !== 32'd384 || o_hash_output_length !== 32'd256) begin
         errors++; $display("FAIL single_len: got %0d/%0d want 384/256", o_hash_input_length, o_hash_output_length);
      end
      step();
      checks++;
      if (o_hash_start !== 1'b0) begin
         errors++; $display("FAIL single_start_width: start still %b in BUSY", o_hash_start);
      end
      i_hash_rd_en = 1'b1; i_hash_addr = 5'd7;
      #1;
      checks++;
      if (o_req_rd_en !== 3'b010 || o_req_addr !== 5'd7 || o_hash_data_in !== 32'hCAFE_0001) begin
         errors++; $display("FAIL single_route: got rd_en=%b addr=%0d din=%h", o_req_rd_en, o_req_addr, o_hash_data_in);
      end
      i_hash_rd_en = 1'b0;
      i_req_force_done = 3'b010;
      #1;
      checks++;
      if (o_hash_force_done !== 1'b0) begin
         errors++; $display("FAIL single_fd_early: got %b want 0 same cycle", o_hash_force_done);
      end
      step();
      i_req_force_done = '0;
      checks++;
      if (o_hash_force_done !== 1'b1 || o_hash_input_length !== 32'd384) begin
         errors++; $display("FAIL single_fd: got fd=%b len=%0d want 1/384", o_hash_force_done, o_hash_input_length);
      end
      i_hash_force_done_ack = 1'b1;
      #1;
      checks++;
      if (o_req_force_done_ack !== 3'b010) begin
         errors++; $display("FAIL single_ack: got %b want 010", o_req_force_done_ack);
      end
      step();
      i_hash_force_done_ack = 1'b0;
      checks++;
      if (o_grant !== 3'b000 || o_hash_force_done !== 1'b0) begin
         errors++; $display("FAIL single_idle: got grant=%b fd=%b want 000/0", o_grant, o_hash_force_done);
      end
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] exp [4];
      logic [N-1:0] g;
      bit ok;
`ifdef HASH_ARB_FIXED_PRIO_EN
      exp = '{3'b001, 3'b001, 3'b010, 3'b100};
`else
      exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
      do_reset();
      pulse_start(3'b111);
      for (int n = 0; n < 4; n++) begin
         wait_start(g, ok);
         checks++;
         if (!ok || g !== exp[n]) begin
            errors++; $display("FAIL simul_order[%0d]: got ok=%0d grant=%b want %b", n, ok, g, exp[n]);
         end
         step();
         if (n == 0) pulse_start(3'b001);
         do_flush(g);
      end
   endtask

   task automatic test_isolation();
      logic [N-1:0] g;
      bit ok;
      do_reset();
      i_req_data_in[31:0] = 32'h0000_AAAA; i_req_data_in[95:64] = 32'hBAD0_0002;
      pulse_start(3'b001);
      wait_start(g, ok);
      step();
      i_req_ready = 3'b100; i_req_force_done = 3'b100;
      i_hash_data_out_valid = 1'b1; i_hash_data_out = 32'h0000_1234; i_hash_rd_en = 1'b1;
      #1;
      checks++;
      if (o_hash_data_out_ready !== 1'b0) begin
         errors++; $display("FAIL iso_ready: got %b want 0", o_hash_data_out_ready);
      end
      checks++;
      if (o_req_valid !== 3'b001 || o_req_rd_en !== 3'b001) begin
         errors++; $display("FAIL iso_owner_bits: got valid=%b rd_en=%b want 001/001", o_req_valid, o_req_rd_en);
      end
      checks++;
      if (o_hash_data_in !== 32'h0000_AAAA || o_req_data_out !== 32'h0000_1234) begin
         errors++; $display("FAIL iso_data: got din=%h dout=%h want 0000aaaa/00001234", o_hash_data_in, o_req_data_out);
      end
      step();
      clear_inputs();
      checks++;
      if (o_hash_force_done !== 1'b0 || o_grant !== 3'b001 || o_req_force_done_ack !== 3'b000) begin
         errors++; $display("FAIL iso_fd: got fd=%b grant=%b ack=%b want 0/001/000", o_hash_force_done, o_grant, o_req_force_done_ack);
      end
      do_flush(3'b001);
   endtask

   task automatic test_backpressure();
      logic [N-1:0] g;
      bit ok;
      logic [7:0] rdy_pat;
      int sent, got;
      bit seq_ok;
      rdy_pat = 8'b1110_0011;
      sent = 0; got = 0; seq_ok = 1'b1;
      do_reset();
      pulse_start(3'b100);
      wait_start(g, ok);
      step();
      for (int k = 0; k < 8; k++) begin
         i_req_ready = {rdy_pat[k], 2'b00};
         i_hash_data_out_valid = 1'b1;
         i_hash_data_out = 32'h100 + sent;
         #1;
         checks++;
         if (o_hash_data_out_ready !== rdy_pat[k] || o_req_valid !== 3'b100) begin
            errors++; $display("FAIL bp_ready[%0d]: got ready=%b valid=%b want %b/100", k, o_hash_data_out_ready, o_req_valid, rdy_pat[k]);
         end
         if (o_req_valid[2] && i_req_ready[2]) begin
            if (o_req_data_out !== 32'h100 + got) seq_ok = 1'b0;
            got++;
         end
         if (o_hash_data_out_ready) sent++;
         step();
      end
      clear_inputs();
      checks++;
      if (got != 5 || sent != 5 || !seq_ok) begin
         errors++; $display("FAIL bp_words: got recv=%0d sent=%0d in_order=%0d want 5/5/1", got, sent, seq_ok);
      end
      do_flush(3'b100);
   endtask

   task automatic test_reset_busy();
      logic [N-1:0] g;
      bit ok;
      int starts;
      do_reset();
      i_req_in_len[31:0] = 32'd100;
      pulse_start(3'b001);
      wait_start(g, ok);
      step();
      pulse_start(3'b010);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      checks++;
      if ({o_grant, o_hash_start, o_hash_force_done, o_hash_input_length, o_hash_output_length, o_req_rd_en, o_req_valid} !== '0) begin
         errors++; $display("FAIL rst_busy_out: got grant=%b start=%b len=%0d want zeros", o_grant, o_hash_start, o_hash_input_length);
      end
      checks++;
      if (dut.pend !== 3'b000) begin
         errors++; $display("FAIL rst_busy_pend: got %b want 000", dut.pend);
      end
      starts = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (o_hash_start === 1'b1 || o_grant !== 3'b000) starts++;
      end
      checks++;
      if (starts != 0) begin
         errors++; $display("FAIL rst_busy_regrant: got %0d grant cycles want 0", starts);
      end
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] g;
      bit ok;
      do_reset();
      pulse_start(3'b011);
      wait_start(g, ok);
      checks++;
      if (!ok || g !== 3'b001) begin
         errors++; $display("FAIL b2b_first: got ok=%0d grant=%b want 001", ok, g);
      end
      step();
      do_flush(3'b001);
      checks++;
      if (o_grant !== 3'b000 || o_hash_start !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: got grant=%b start=%b want 000/0", o_grant, o_hash_start);
      end
      step();
      checks++;
      if (o_hash_start !== 1'b1 || o_grant !== 3'b010) begin
         errors++; $display("FAIL b2b_second: got start=%b grant=%b want 1/010", o_hash_start, o_grant);
      end
      step();
      do_flush(3'b010);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      i_rst = 1'b1;
      test_reset();
      test_single();
      test_simultaneous();
      test_isolation();
      test_backpressure();
      test_reset_busy();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
